// File: rtl/param_universal_shift_register_if.sv
// Control/data bundle for the universal shift register.
// The master side drives mode, data and burst requests; the slave side returns register state.
interface param_universal_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       sel;
  logic [WIDTH-1:0] parin;
  logic             sin_r;
  logic             sin_l;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] out;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  modport master (
    output en, sel, parin, sin_r, sin_l, start, cnt,
    input  out, sout_r, sout_l, busy, done
  );

  modport slave (
    input  en, sel, parin, sin_r, sin_l, start, cnt,
    output out, sout_r, sout_l, busy, done
  );
endinterface

// File: rtl/param_universal_shift_register.sv
// WIDTH-bit universal shift register with per-cycle modes and a counted burst engine.
// Bursts repeat one shift/rotate mode cnt times under a start/busy/done handshake.
module param_universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic clr,
  param_universal_shift_register_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       mreg_q, mreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;

  // One step of the selected mode applied to the current contents.
  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] cur,
    input logic             s_r,
    input logic             s_l,
    input logic [WIDTH-1:0] par
  );
    logic [WIDTH-1:0] nxt;
    case (mode)
      3'b001:  nxt = {s_r, cur[WIDTH-1:1]};
      3'b010:  nxt = {cur[WIDTH-2:0], s_l};
      3'b011:  nxt = par;
      3'b100:  nxt = {cur[0], cur[WIDTH-1:1]};
      3'b101:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b110:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Only genuine shift/rotate modes can be repeated; hold and load requests just acknowledge.
  function automatic logic burstable(input logic [2:0] mode);
    logic ok;
    case (mode)
      3'b001, 3'b010, 3'b100, 3'b101, 3'b110: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next-state, counter, datapath and done-pulse logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mreg_d  = mreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (burstable(bus.sel) && (bus.cnt != CNT_ZERO)) begin
              mreg_d  = bus.sel;
              rem_d   = bus.cnt;
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            data_d = step_op(bus.sel, data_q, bus.sin_r, bus.sin_l, bus.parin);
          end
        end
        RUN: begin
          data_d = step_op(mreg_q, data_q, bus.sin_r, bus.sin_l, bus.parin);
          rem_d  = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, counter, latched mode and register contents.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      rem_q   <= CNT_ZERO;
      mreg_q  <= 3'b000;
      data_q  <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mreg_q  <= mreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign bus.out    = data_q;
  assign bus.sout_r = data_q[0];
  assign bus.sout_l = data_q[WIDTH-1];
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed bench: per-cycle modes on a 4-bit instance, burst handshake corners on an 8-bit one.
module tb_param_universal_shift_register;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  param_universal_shift_register_if #(.WIDTH(4), .CNT_W(4)) if4 ();
  param_universal_shift_register_if #(.WIDTH(8), .CNT_W(4)) if8 ();

  param_universal_shift_register #(.WIDTH(4), .CNT_W(4)) u4 (
    .clk(clk), .clr(clr), .bus(if4)
  );
  param_universal_shift_register #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk(clk), .clr(clr), .bus(if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] parin;
    logic       sin_r;
    logic       sin_l;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks {out, busy, done} of the 8-bit instance.
  task automatic chk8(input string name, input logic [7:0] o, input logic b, input logic d);
    check(name, {22'd0, if8.out, if8.busy, if8.done}, {22'd0, o, b, d});
  endtask

  initial begin
    logic [7:0] model;
    checks = 0;
    errors = 0;
    clr = 1'b1;
    if4.en = 1'b0; if4.sel = 3'b000; if4.parin = 4'h0; if4.sin_r = 1'b0;
    if4.sin_l = 1'b0; if4.start = 1'b0; if4.cnt = 4'd0;
    if8.en = 1'b0; if8.sel = 3'b000; if8.parin = 8'h00; if8.sin_r = 1'b0;
    if8.sin_l = 1'b0; if8.start = 1'b0; if8.cnt = 4'd0;

    vecs[0]  = '{3'b011, 4'b1011, 1'b0, 1'b0, 4'b1011};
    vecs[1]  = '{3'b000, 4'b0000, 1'b0, 1'b0, 4'b1011};
    vecs[2]  = '{3'b001, 4'b0000, 1'b0, 1'b0, 4'b0101};
    vecs[3]  = '{3'b010, 4'b0000, 1'b0, 1'b1, 4'b1011};
    vecs[4]  = '{3'b110, 4'b0000, 1'b0, 1'b0, 4'b1101};
    vecs[5]  = '{3'b100, 4'b0000, 1'b0, 1'b0, 4'b1110};
    vecs[6]  = '{3'b101, 4'b0000, 1'b0, 1'b0, 4'b1101};
    vecs[7]  = '{3'b111, 4'b0110, 1'b1, 1'b1, 4'b1101};
    vecs[8]  = '{3'b001, 4'b0000, 1'b1, 1'b0, 4'b1110};
    vecs[9]  = '{3'b010, 4'b0000, 1'b1, 1'b0, 4'b1100};
    vecs[10] = '{3'b110, 4'b0000, 1'b0, 1'b1, 4'b1110};

    #12;
    check("reset4", {26'd0, if4.out, if4.busy, if4.done}, 32'd0);
    check("reset8", {19'd0, if8.out, if8.sout_r, if8.sout_l, if8.busy, if8.done}, 32'd0);
    clr = 1'b0;
    tick();

    // Per-cycle modes, WIDTH=4
    if4.en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if4.sel   = vecs[i].sel;
      if4.parin = vecs[i].parin;
      if4.sin_r = vecs[i].sin_r;
      if4.sin_l = vecs[i].sin_l;
      tick();
      check($sformatf("vec%0d", i),
            {24'd0, if4.out, if4.sout_l, if4.sout_r, if4.busy, if4.done},
            {24'd0, vecs[i].exp, vecs[i].exp[3], vecs[i].exp[0], 1'b0, 1'b0});
    end
    if4.sel = 3'b000;

    // Rotate-right burst of 3 from 0x81
    if8.en = 1'b1; if8.sel = 3'b011; if8.parin = 8'h81;
    tick();
    chk8("load81", 8'h81, 1'b0, 1'b0);
    if8.start = 1'b1; if8.sel = 3'b100; if8.cnt = 4'd3;
    tick();
    chk8("rr_accept", 8'h81, 1'b1, 1'b0);
    if8.start = 1'b0; if8.sel = 3'b011; if8.parin = 8'hAA; if8.cnt = 4'd9;
    tick();
    chk8("rr_step1", 8'hC0, 1'b1, 1'b0);
    tick();
    chk8("rr_step2", 8'h60, 1'b1, 1'b0);
    tick();
    chk8("rr_done", 8'h30, 1'b0, 1'b1);
    if8.sel = 3'b000;
    tick();
    chk8("rr_after", 8'h30, 1'b0, 1'b0);

    // ASR burst of 10 from 0x80 with two paused cycles
    if8.sel = 3'b011; if8.parin = 8'h80;
    tick();
    if8.start = 1'b1; if8.sel = 3'b110; if8.cnt = 4'd10;
    tick();
    chk8("asr_accept", 8'h80, 1'b1, 1'b0);
    if8.start = 1'b0; if8.sel = 3'b000;
    model = 8'h80;
    for (int i = 1; i <= 12; i++) begin
      if8.en = (i == 4 || i == 5) ? 1'b0 : 1'b1;
      if (if8.en) model = {model[7], model[7:1]};
      tick();
      if (i < 12) chk8($sformatf("asr_edge%0d", i), model, 1'b1, 1'b0);
      else        chk8("asr_done", 8'hFF, 1'b0, 1'b1);
    end
    if8.en = 1'b1;
    tick();
    chk8("asr_after", 8'hFF, 1'b0, 1'b0);

    // Non-burst start requests only acknowledge
    if8.start = 1'b1; if8.sel = 3'b001; if8.cnt = 4'd0;
    tick();
    chk8("cnt0_ack", 8'hFF, 1'b0, 1'b1);
    if8.start = 1'b0; if8.sel = 3'b000;
    tick();
    chk8("cnt0_after", 8'hFF, 1'b0, 1'b0);
    if8.start = 1'b1; if8.sel = 3'b011; if8.cnt = 4'd5; if8.parin = 8'h00;
    tick();
    chk8("load_ack", 8'hFF, 1'b0, 1'b1);
    if8.start = 1'b0; if8.sel = 3'b000;
    tick();
    chk8("load_after", 8'hFF, 1'b0, 1'b0);

    // Abort a rotate-left burst with clr at step 2
    if8.sel = 3'b011; if8.parin = 8'h01;
    tick();
    if8.start = 1'b1; if8.sel = 3'b101; if8.cnt = 4'd5;
    tick();
    if8.start = 1'b0; if8.sel = 3'b000;
    tick();
    chk8("rl_step1", 8'h02, 1'b1, 1'b0);
    tick();
    chk8("rl_step2", 8'h04, 1'b1, 1'b0);
    #2;
    clr = 1'b1;
    #1;
    chk8("clr_abort", 8'h00, 1'b0, 1'b0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk8($sformatf("no_done%0d", i), 8'h00, 1'b0, 1'b0);
    end

    // Fresh shift-left burst after the abort
    if8.start = 1'b1; if8.sel = 3'b010; if8.cnt = 4'd2; if8.sin_l = 1'b1;
    tick();
    chk8("sl_accept", 8'h00, 1'b1, 1'b0);
    if8.start = 1'b0; if8.sel = 3'b000;
    tick();
    chk8("sl_step1", 8'h01, 1'b1, 1'b0);
    tick();
    chk8("sl_done", 8'h03, 1'b0, 1'b1);
    check("sl_souts", {30'd0, if8.sout_l, if8.sout_r}, {30'd0, 1'b0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_universal_shift_register.md
# param_universal_shift_register

Parametrised universal shift register: WIDTH-bit storage with hold, logical shift left/right, parallel load, rotate left/right and arithmetic shift right. A burst engine performs a selected shift/rotate a programmed number of times under a start/busy/done handshake. It is the next-generation replacement for the fixed 4-bit universal shift register and is used wherever the datapath needs multi-position shifts without an external sequencer.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of burst count input; bursts of 0..2^CNT_W-1 steps
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-high reset
- en  input  1  clock enable; 0 freezes register, FSM and counter
- sel  input  3  mode: 000 hold, 001 shift right, 010 shift left, 011 parallel load, 100 rotate right, 101 rotate left, 110 arithmetic shift right, 111 hold
- parin  input  WIDTH  parallel load data
- sin_r  input  1  serial in, enters MSB on shift right
- sin_l  input  1  serial in, enters LSB on shift left
- start  input  1  request burst of cnt steps of mode sel
- cnt  input  CNT_W  burst step count
- out  output  WIDTH  register contents
- sout_r  output  1  out[0]
- sout_l  output  1  out[WIDTH-1]
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse after the final burst step

## Operation
- Per-step ops: SR out<={sin_r,out[W-1:1]}; SL out<={out[W-2:0],sin_l}; LOAD out<=parin; RR out<={out[0],out[W-1:1]}; RL out<={out[W-2:0],out[W-1]}; ASR out<={out[W-1],out[W-1:1]}; hold/111 unchanged.
- FSM states: IDLE, RUN. Counter rem (CNT_W bits), latched mode mreg (3 bits).
- IDLE, en=1, start=0: execute sel op on every edge (classic USR behaviour).
- IDLE, en=1, start=1, sel in {001,010,100,101,110}, cnt≠0: accept; mreg<=sel, rem<=cnt, go RUN; register does NOT change on the accept edge.
- IDLE, start=1, cnt=0 or sel in {000,011,111}: no burst, register unchanged, done pulses next cycle.
- RUN, en=1: execute mreg op, rem<=rem-1; if rem==1, go IDLE and set done for one cycle.
- RUN, en=0: pause; register, rem and state frozen.
- In RUN, sel, parin, start and cnt are ignored; sin_r/sin_l are sampled live on every step.
- cnt > WIDTH is legal: rotates wrap modulo WIDTH, shifts fill entirely with serial input or sign bit.
- clr (any time, including mid-burst): out=0, state IDLE, rem=0, mreg=000, busy=0, done=0; an aborted burst never produces done.

## Timing
- Reset values: out=0, sout_r=0, sout_l=0, busy=0, done=0.
- All outputs are registered or direct slices of registers; none is combinational from inputs.
- busy=1 from the edge after accept through the edge of the final step (inclusive of cycles paused by en=0).
- Burst latency with en held 1: accept at edge 0, steps at edges 1..cnt, busy falls and done rises at edge cnt, done falls at edge cnt+1.
- Burst with en=0 gaps: latency = cnt + number of paused cycles.
- New start is accepted in the cycle done=1 (FSM already IDLE); back-to-back bursts have one accept cycle between them.
- Classic per-cycle ops in IDLE take effect at the next rising edge, latency 1.

## Test plan
- WIDTH=4: clr=1 then release; sel=011, parin=1011, en=1 -> out=1011 after one edge; sel=000 -> holds 1011.
- WIDTH=4, out=1011: sel=001 sin_r=0 -> 0101; sel=010 sin_l=1 -> 1011; sel=110 -> 1101; sel=100 -> 1110; sel=101 -> 1101.
- WIDTH=8, out=0x81: start, sel=100, cnt=3 -> busy high 3 cycles, out=0x30 at final edge, done one-cycle pulse, busy low.
- WIDTH=8, out=0x80: start, sel=110, cnt=10 -> out=0xFF at done; en toggled 0 for 2 cycles mid-burst -> done 2 cycles later, same result.
- start with cnt=0 and start with sel=011 -> out unchanged, done pulses once, busy stays 0.
- clr asserted at step 2 of a cnt=5 burst -> out=0, busy=0 immediately, no done pulse; next start accepted normally.
